mips_regfile_mp: RTL and testbench
==================================

// Module: mips_regfile_mp
// PURPOSE
//  Parametrised multi-port MIPS32 general-purpose register file with per-register busy scoreboard.
//  Successor to the 2R/2W register file: generic width, depth and read/write port counts.
//  Adds asynchronous reset, deterministic write-conflict priority and optional write-to-read bypass.
//  Sits between decode/issue (reads, busy checks, destination reservation) and writeback (writes).
// PARAMETERS
//  DATA_W  32  register width in bits
//  ADDR_W  5   register address width; depth = 2**ADDR_W
//  NUM_RD  2   number of read ports, 1..8
//  NUM_WR  2   number of write ports, 1..4
// PORTS
//  clk       in   1              rising-edge clock; the block's only clock
//  rst_n     in   1              asynchronous active-low reset
//  rd_addr   in   NUM_RD*ADDR_W  read addresses; port k = bits [k*ADDR_W +: ADDR_W]
//  rd_data   out  NUM_RD*DATA_W  read data, combinational; port k = [k*DATA_W +: DATA_W]
//  rd_busy   out  NUM_RD         1 = addressed register has a pending producer
//  wr_en     in   NUM_WR         per-port write enable
//  wr_addr   in   NUM_WR*ADDR_W  write addresses, packed as rd_addr
//  wr_data   in   NUM_WR*DATA_W  write data, packed as rd_data
//  iss_en    in   1              reserve the destination register: set its busy bit
//  iss_addr  in   ADDR_W         destination register being reserved
//  busy_cnt  out  ADDR_W+1       number of registers currently busy
// BEHAVIOUR
//  - Reset: on rst_n low, immediately clear all registers and busy bits; busy_cnt=0.
//    rd_data follows the cleared array (0). Reset mid-write discards the write.
//  - Register 0: always reads 0 and is never busy; writes and issues to address 0 are ignored.
//  - Write: on posedge clk, registers[wr_addr[j]] <= wr_data[j] for each port j with wr_en[j]=1.
//  - Write conflict: if several enabled ports target the same address, the highest-index port wins.
//  - Read: rd_data[k] = registers[rd_addr[k]], combinational, with zero latency.
//    Any number of read ports may use the same address.
//  - Scoreboard, on each posedge clk:
//    - An enabled write to register r clears busy[r].
//    - iss_en with iss_addr=r sets busy[r].
//    - If both happen to the same r in the same cycle, set wins: a new producer overrides writeback.
//    - Issuing to a register that is already busy keeps it busy (no error, no counting).
//    - rd_busy[k] = busy[rd_addr[k]], combinational.
//  - busy_cnt: registered population count of busy[]; updates in the cycle after the busy change.
//    Range 0..2**ADDR_W-1, because register 0 is never busy.
//  - Interface widths are fixed by the parameters. No X may propagate from disabled write ports.
// CONFIGURATION
//  MIPS_RF_BYPASS_EN defined:
//    - If any enabled write port targets rd_addr[k]!=0 in the current cycle, rd_data[k] returns
//      that port's wr_data. When several ports match, the highest-index port is returned.
//    - rd_busy[k] reads 0 for a register being written, unless iss_en targets the same register
//      in the same cycle.
//    - Result: a same-cycle read sees the write (write-first).
//  MIPS_RF_BYPASS_EN undefined:
//    - rd_data and rd_busy show only the stored state; the write is visible from the next cycle.
// TESTING
//  1 Reset: write 0xDEADBEEF to r5, then pulse rst_n low between edges -> rd_data(r5)=0 at once;
//    busy_cnt=0.
//  2 Zero register: wr_en[0]=1, wr_addr=0, data 0x12345678; iss_en to r0 -> r0 reads 0, rd_busy=0.
//  3 Conflict: ports 0 and 1 both write r7 (0x1111 vs 0x2222) -> next cycle r7=0x2222 on all reads.
//  4 Bypass: write r9=0xCAFE0001 while reading r9 in the same cycle. With the macro -> rd_data=0xCAFE0001.
//    Without the macro -> old value, then 0xCAFE0001 in the next cycle.
//  5 Scoreboard: issue r3 -> rd_busy=1 and busy_cnt=1 a cycle later.
//    Issue r3 and write r3 together -> still busy.
//    Write r3 alone -> rd_busy=0, then busy_cnt=0.
//  6 Saturation: issue r1..r31 over 31 cycles -> busy_cnt=31. Writes to r1..r31 on both ports -> busy_cnt=0.

Source files
------------

// File: rtl/mips_regfile_mp.sv
// Multi-port MIPS32 register file with per-register busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining MIPS_RF_BYPASS_EN.
module mips_regfile_mp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic [ADDR_W:0]   r_busy_cnt;
    logic [ADDR_W:0]   w_pop;
    logic [ADDR_W-1:0] w_rd_a [NUM_RD];
    logic [NUM_RD-1:0] w_byp_hit;

    // Later ports overwrite earlier ones, so the highest-index writer wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int j = 0; j < int'(NUM_WR); j++) begin
                if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
                    r_regs[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Issue is applied after writeback clears so a new producer keeps the register busy.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int j = 0; j < int'(NUM_WR); j++) begin
            if (wr_en[j]) begin
                w_busy_nxt[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (iss_en) begin
            w_busy_nxt[iss_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_pop = w_pop + {{ADDR_W{1'b0}}, r_busy[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_pop;
        end
    end

    assign busy_cnt = r_busy_cnt;

    always_comb begin
        rd_data   = '0;
        rd_busy   = '0;
        w_byp_hit = '0;
        for (int k = 0; k < int'(NUM_RD); k++) begin
            w_rd_a[k]                     = rd_addr[k*ADDR_W +: ADDR_W];
            rd_data[k*DATA_W +: DATA_W]   = r_regs[w_rd_a[k]];
            rd_busy[k]                    = r_busy[w_rd_a[k]];
`ifdef MIPS_RF_BYPASS_EN
            for (int j = 0; j < int'(NUM_WR); j++) begin
                if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == w_rd_a[k]) &&
                    (w_rd_a[k] != '0)) begin
                    rd_data[k*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
                    w_byp_hit[k]                = 1'b1;
                end
            end
            if (w_byp_hit[k] && !(iss_en && (iss_addr == w_rd_a[k]))) begin
                rd_busy[k] = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Directed self-checking bench for mips_regfile_mp (default 32x32, 2 read / 2 write ports).
module tb_mips_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [5:0]  busy_cnt;

    int n_vec;
    int n_err;

`ifdef MIPS_RF_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    mips_regfile_mp #(
        .DATA_W (32),
        .ADDR_W (5),
        .NUM_RD (2),
        .NUM_WR (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 2'b00;
        iss_en = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        rd_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        #2;
        chk("rst_rd0", rd_data[31:0], 32'h0);
        chk("rst_cnt", {26'h0, busy_cnt}, 32'h0);
        #10 rst_n = 1'b1;

        // 1: reset clears data and scoreboard immediately
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
        iss_en = 1'b1; iss_addr = 5'd5; rd_addr = {5'd5, 5'd5};
        tick(); idle();
        chk("r5_written", rd_data[31:0], 32'hDEADBEEF);
        chk("r5_busy", {31'h0, rd_busy[0]}, 32'h1);
        tick();
        chk("cnt_one", {26'h0, busy_cnt}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_r5_p0", rd_data[31:0], 32'h0);
        chk("rst_r5_p1", rd_data[63:32], 32'h0);
        chk("rst_busy", {30'h0, rd_busy}, 32'h0);
        chk("rst_cnt2", {26'h0, busy_cnt}, 32'h0);
        #1 rst_n = 1'b1;

        // 2: register 0 ignores writes and issues
        wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'h12345678};
        iss_en = 1'b1; iss_addr = 5'd0; rd_addr = {5'd0, 5'd0};
        tick(); idle();
        chk("r0_data", rd_data[31:0], 32'h0);
        chk("r0_busy", {31'h0, rd_busy[0]}, 32'h0);
        tick();
        chk("r0_cnt", {26'h0, busy_cnt}, 32'h0);

        // 3: write conflict, highest port wins
        wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h2222, 32'h1111};
        rd_addr = {5'd7, 5'd7};
        #1;
        chk("conf_same_cyc", rd_data[31:0], Byp ? 32'h2222 : 32'h0);
        tick(); idle();
        chk("conf_p0", rd_data[31:0], 32'h2222);
        chk("conf_p1", rd_data[63:32], 32'h2222);

        // 4: bypass of data and busy
        iss_en = 1'b1; iss_addr = 5'd9; rd_addr = {5'd7, 5'd9};
        tick(); idle();
        wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'hCAFE0001, 32'h0};
        #1;
        chk("byp_data", rd_data[31:0], Byp ? 32'hCAFE0001 : 32'h0);
        chk("byp_busy", {31'h0, rd_busy[0]}, Byp ? 32'h0 : 32'h1);
        chk("byp_other", rd_data[63:32], 32'h2222);
        tick(); idle();
        chk("r9_next", rd_data[31:0], 32'hCAFE0001);
        chk("r9_free", {31'h0, rd_busy[0]}, 32'h0);
        tick();

        // 5: scoreboard set/clear/priority and lagging count
        iss_en = 1'b1; iss_addr = 5'd3; rd_addr = {5'd0, 5'd3};
        tick(); idle();
        chk("r3_busy", {31'h0, rd_busy[0]}, 32'h1);
        chk("cnt_lag", {26'h0, busy_cnt}, 32'h0);
        tick();
        chk("cnt_r3", {26'h0, busy_cnt}, 32'h1);
        iss_en = 1'b1; iss_addr = 5'd3;
        wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h00000033};
        #1;
        chk("set_wins_comb", {31'h0, rd_busy[0]}, 32'h1);
        tick(); idle();
        chk("set_wins", {31'h0, rd_busy[0]}, 32'h1);
        chk("r3_data", rd_data[31:0], 32'h33);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h00000034};
        #1;
        chk("clr_comb", {31'h0, rd_busy[0]}, Byp ? 32'h0 : 32'h1);
        tick(); idle();
        chk("clr_busy", {31'h0, rd_busy[0]}, 32'h0);
        chk("clr_cnt_lag", {26'h0, busy_cnt}, 32'h1);
        tick();
        chk("clr_cnt", {26'h0, busy_cnt}, 32'h0);

        // 6: saturate the scoreboard, then drain it on both write ports
        for (int i = 1; i <= 31; i++) begin
            iss_en = 1'b1; iss_addr = 5'(i);
            tick();
        end
        idle();
        tick();
        chk("sat_cnt", {26'h0, busy_cnt}, 32'd31);
        rd_addr = {5'd31, 5'd1};
        #1;
        chk("sat_busy", {30'h0, rd_busy}, 32'h3);
        for (int i = 1; i <= 31; i += 2) begin
            wr_en   = 2'b11;
            wr_addr = {5'(i + 1), 5'(i)};
            wr_data = {32'h100 + 32'(i + 1), 32'h100 + 32'(i)};
            tick();
        end
        idle();
        tick();
        chk("drain_cnt", {26'h0, busy_cnt}, 32'h0);
        rd_addr = {5'd16, 5'd31};
        #1;
        chk("drain_r31", rd_data[31:0], 32'h11F);
        chk("drain_r16", rd_data[63:32], 32'h110);
        rd_addr = {5'd0, 5'd0};
        #1;
        chk("drain_r0", rd_data[31:0], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
